// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences one CSR instruction at a time into the CSR data
// block (read, read-modify-write or write) and returns the old value.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_*               decoded CSR instruction from SFU issue (valid/ready)
//   read_*              read strobe + qualifiers; read_data_ro/rw come back
//                       combinationally in the same cycle
//   write_*             write strobe + qualifiers + data
//   rsp_*               old CSR value to writeback (valid/ready)
module csr_access_ctrl #(
  parameter int XLEN          = 32,
  parameter int NW_WIDTH      = 2,
  parameter int UUID_WIDTH    = 44,
  parameter int CSR_ADDR_BITS = 12
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [UUID_WIDTH-1:0]    req_uuid,
  input  logic [NW_WIDTH-1:0]      req_wid,
  input  logic [CSR_ADDR_BITS-1:0] req_addr,
  input  logic [1:0]               req_op,
  input  logic                     req_use_imm,
  input  logic [4:0]               req_imm,
  input  logic [XLEN-1:0]          req_rs1_data,
  input  logic                     req_rd_zero,
  input  logic                     req_src_zero,

  output logic                     read_enable,
  output logic [UUID_WIDTH-1:0]    read_uuid,
  output logic [NW_WIDTH-1:0]      read_wid,
  output logic [CSR_ADDR_BITS-1:0] read_addr,
  input  logic [XLEN-1:0]          read_data_ro,
  input  logic [XLEN-1:0]          read_data_rw,

  output logic                     write_enable,
  output logic [UUID_WIDTH-1:0]    write_uuid,
  output logic [NW_WIDTH-1:0]      write_wid,
  output logic [CSR_ADDR_BITS-1:0] write_addr,
  output logic [XLEN-1:0]          write_data,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [UUID_WIDTH-1:0]    rsp_uuid,
  output logic [NW_WIDTH-1:0]      rsp_wid,
  output logic [XLEN-1:0]          rsp_data
);

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RSP    = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [UUID_WIDTH-1:0]    uuid_q;
  logic [NW_WIDTH-1:0]      wid_q;
  logic [CSR_ADDR_BITS-1:0] addr_q;
  logic [1:0]               op_q;
  logic                     rd_zero_q;
  logic                     src_zero_q;
  logic [XLEN-1:0]          src_q;
  logic [XLEN-1:0]          data_q;

  logic                     accept;
  logic                     do_read;
  logic                     do_write;
  logic [XLEN-1:0]          old_val;
  logic [XLEN-1:0]          wdata;

  assign accept = (state == IDLE) & req_valid;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = ACCESS;
      ACCESS:  state_n = RSP;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // instruction context, held stable for ACCESS and RSP
  always_ff @(posedge clk) begin
    if (accept) begin
      uuid_q     <= req_uuid;
      wid_q      <= req_wid;
      addr_q     <= req_addr;
      op_q       <= req_op;
      rd_zero_q  <= req_rd_zero;
      src_zero_q <= req_src_zero;
      src_q      <= req_use_imm ? XLEN'(req_imm) : req_rs1_data;
    end
  end

  // old value captured at the end of ACCESS
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (state == ACCESS) begin
      data_q <= old_val;
    end
  end

  // a plain CSRRW into x0 skips the read to avoid read side effects
  assign do_read  = ~((op_q == OP_RW) & rd_zero_q);
  assign do_write = (op_q == OP_RW)
                  | (((op_q == OP_RS) | (op_q == OP_RC)) & ~src_zero_q);

  assign old_val = do_read ? (read_data_ro | read_data_rw) : '0;

  always_comb begin
    wdata = old_val;
    unique case (op_q)
      OP_RW:   wdata = src_q;
      OP_RS:   wdata = old_val | src_q;
      OP_RC:   wdata = old_val & ~src_q;
      OP_RD:   wdata = old_val;
      default: wdata = old_val;
    endcase
  end

  // outputs; strobes are gated by reset so an aborted access never
  // commits at the reset edge
  always_comb begin
    req_ready    = (state == IDLE);
    read_enable  = (state == ACCESS) & do_read & ~reset;
    write_enable = (state == ACCESS) & do_write & ~reset;
    rsp_valid    = (state == RSP);
  end

  assign read_uuid  = uuid_q;
  assign read_wid   = wid_q;
  assign read_addr  = addr_q;
  assign write_uuid = uuid_q;
  assign write_wid  = wid_q;
  assign write_addr = addr_q;
  assign write_data = wdata;
  assign rsp_uuid   = uuid_q;
  assign rsp_wid    = wid_q;
  assign rsp_data   = data_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed bench for csr_access_ctrl with a small CSR
// data block model (mscratch read/write, vendor id read-only).
module tb_csr_access_ctrl;

  localparam int XLEN = 32;
  localparam int NW = 2;
  localparam int UW = 44;
  localparam int AW = 12;
  localparam logic [XLEN-1:0] VENDOR = 32'hABCD_0001;
  localparam logic [AW-1:0] MSCRATCH = 12'h340;
  localparam logic [AW-1:0] MVENDOR = 12'hF11;

  logic clk = 1'b0;
  logic reset;
  logic req_valid;
  logic req_ready;
  logic [UW-1:0] req_uuid;
  logic [NW-1:0] req_wid;
  logic [AW-1:0] req_addr;
  logic [1:0] req_op;
  logic req_use_imm;
  logic [4:0] req_imm;
  logic [XLEN-1:0] req_rs1_data;
  logic req_rd_zero;
  logic req_src_zero;
  logic read_enable;
  logic [UW-1:0] read_uuid;
  logic [NW-1:0] read_wid;
  logic [AW-1:0] read_addr;
  logic [XLEN-1:0] read_data_ro;
  logic [XLEN-1:0] read_data_rw;
  logic write_enable;
  logic [UW-1:0] write_uuid;
  logic [NW-1:0] write_wid;
  logic [AW-1:0] write_addr;
  logic [XLEN-1:0] write_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [UW-1:0] rsp_uuid;
  logic [NW-1:0] rsp_wid;
  logic [XLEN-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] mscratch;
  logic pre_en = 1'b0;
  logic [XLEN-1:0] pre_val = '0;

  always #5 clk = ~clk;

  csr_access_ctrl #(
    .XLEN(XLEN), .NW_WIDTH(NW), .UUID_WIDTH(UW), .CSR_ADDR_BITS(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_uuid(req_uuid), .req_wid(req_wid), .req_addr(req_addr),
    .req_op(req_op), .req_use_imm(req_use_imm), .req_imm(req_imm),
    .req_rs1_data(req_rs1_data), .req_rd_zero(req_rd_zero),
    .req_src_zero(req_src_zero),
    .read_enable(read_enable), .read_uuid(read_uuid),
    .read_wid(read_wid), .read_addr(read_addr),
    .read_data_ro(read_data_ro), .read_data_rw(read_data_rw),
    .write_enable(write_enable), .write_uuid(write_uuid),
    .write_wid(write_wid), .write_addr(write_addr),
    .write_data(write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid), .rsp_data(rsp_data)
  );

  // CSR data block model: read data is not gated by read_enable
  assign read_data_rw = (read_addr == MSCRATCH) ? mscratch : '0;
  assign read_data_ro = (read_addr == MVENDOR) ? VENDOR : '0;

  always @(posedge clk) begin
    if (pre_en) mscratch <= pre_val;
    else if (write_enable && write_addr == MSCRATCH) mscratch <= write_data;
  end

  task automatic set_csr(input logic [XLEN-1:0] v);
    @(negedge clk);
    pre_en = 1'b1;
    pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // drives one request at a negedge; returns at the negedge inside ACCESS
  task automatic issue(
    input logic [1:0] op, input logic use_imm, input logic [4:0] imm,
    input logic [XLEN-1:0] rs1, input logic rd_zero, input logic src_zero,
    input logic [AW-1:0] addr, input logic [UW-1:0] uuid,
    input logic [NW-1:0] wid);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_use_imm = use_imm;
    req_imm = imm;
    req_rs1_data = rs1;
    req_rd_zero = rd_zero;
    req_src_zero = src_zero;
    req_addr = addr;
    req_uuid = uuid;
    req_wid = wid;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b1;
    req_addr = MSCRATCH;
    req_op = 2'b01;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (read_enable !== 1'b0) begin errors++; $display("FAIL rst_read_en got %b exp 0", read_enable); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rst_write_en got %b exp 0", write_enable); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
  endtask

  task automatic test_rw;
    set_csr(32'h11);
    issue(2'b01, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, MSCRATCH, 44'h1, 2'd2);
    checks++; if (read_enable !== 1'b1) begin errors++; $display("FAIL rw_read_en got %b exp 1", read_enable); end
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rw_write_en got %b exp 1", write_enable); end
    checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_wdata got %h exp deadbeef", write_data); end
    checks++; if (write_addr !== MSCRATCH) begin errors++; $display("FAIL rw_waddr got %h exp 340", write_addr); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rw_ready_access got %b exp 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_early_rsp got %b exp 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rw_rsp_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 32'h11) begin errors++; $display("FAIL rw_rsp_data got %h exp 11", rsp_data); end
    checks++; if (rsp_uuid !== 44'h1) begin errors++; $display("FAIL rw_rsp_uuid got %h exp 1", rsp_uuid); end
    checks++; if (rsp_wid !== 2'd2) begin errors++; $display("FAIL rw_rsp_wid got %h exp 2", rsp_wid); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rw_we_rsp got %b exp 0", write_enable); end
    checks++; if (mscratch !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_csr got %h exp deadbeef", mscratch); end
  endtask

  task automatic test_set_clear;
    set_csr(32'h00F);
    issue(2'b10, 1'b0, 5'd0, 32'h0F0, 1'b0, 1'b0, MSCRATCH, 44'h2, 2'd1);
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rs_write_en got %b exp 1", write_enable); end
    checks++; if (write_data !== 32'h0FF) begin errors++; $display("FAIL rs_wdata got %h exp 0ff", write_data); end
    @(negedge clk);
    checks++; if (rsp_data !== 32'h00F) begin errors++; $display("FAIL rs_rsp_data got %h exp 00f", rsp_data); end
    issue(2'b11, 1'b0, 5'd0, 32'h0F0, 1'b0, 1'b0, MSCRATCH, 44'h3, 2'd1);
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rc_write_en got %b exp 1", write_enable); end
    checks++; if (write_data !== 32'h00F) begin errors++; $display("FAIL rc_wdata got %h exp 00f", write_data); end
    @(negedge clk);
    checks++; if (rsp_data !== 32'h0FF) begin errors++; $display("FAIL rc_rsp_data got %h exp 0ff", rsp_data); end
  endtask

  task automatic test_ro_imm;
    issue(2'b10, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, MVENDOR, 44'h4, 2'd0);
    checks++; if (read_enable !== 1'b1) begin errors++; $display("FAIL ro_read_en got %b exp 1", read_enable); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL ro_write_en got %b exp 0", write_enable); end
    @(negedge clk);
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL ro_we_rsp got %b exp 0", write_enable); end
    checks++; if (rsp_data !== VENDOR) begin errors++; $display("FAIL ro_rsp_data got %h exp %h", rsp_data, VENDOR); end
  endtask

  task automatic test_rd_zero;
    set_csr(32'h5A5A);
    issue(2'b01, 1'b1, 5'h1B, 32'hFFFF_FFFF, 1'b1, 1'b0, MSCRATCH, 44'h5, 2'd3);
    checks++; if (read_enable !== 1'b0) begin errors++; $display("FAIL rdz_read_en got %b exp 0", read_enable); end
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rdz_write_en got %b exp 1", write_enable); end
    checks++; if (write_data !== 32'h1B) begin errors++; $display("FAIL rdz_wdata got %h exp 1b", write_data); end
    @(negedge clk);
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rdz_rsp_data got %h exp 0", rsp_data); end
  endtask

  task automatic test_back_to_back;
    set_csr(32'h77);
    rsp_ready = 1'b0;
    issue(2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, MSCRATCH, 44'hA, 2'd1);
    // second request held by upstream for the whole stall
    req_valid = 1'b1;
    req_op = 2'b01;
    req_use_imm = 1'b0;
    req_rs1_data = 32'h1234;
    req_rd_zero = 1'b0;
    req_src_zero = 1'b0;
    req_addr = MSCRATCH;
    req_uuid = 44'hB;
    req_wid = 2'd2;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d] got %b exp 1", i, rsp_valid); end
      checks++; if (rsp_data !== 32'h77) begin errors++; $display("FAIL bp_rsp_data[%0d] got %h exp 77", i, rsp_data); end
      checks++; if (rsp_uuid !== 44'hA) begin errors++; $display("FAIL bp_rsp_uuid[%0d] got %h exp a", i, rsp_uuid); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got %b exp 0", i, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_rsp got %b exp 0", rsp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (read_enable !== 1'b1) begin errors++; $display("FAIL bp2_read_en got %b exp 1", read_enable); end
    checks++; if (write_uuid !== 44'hB) begin errors++; $display("FAIL bp2_wuuid got %h exp b", write_uuid); end
    checks++; if (write_data !== 32'h1234) begin errors++; $display("FAIL bp2_wdata got %h exp 1234", write_data); end
    @(negedge clk);
    checks++; if (rsp_data !== 32'h77) begin errors++; $display("FAIL bp2_rsp_data got %h exp 77", rsp_data); end
    checks++; if (rsp_uuid !== 44'hB) begin errors++; $display("FAIL bp2_rsp_uuid got %h exp b", rsp_uuid); end
  endtask

  task automatic test_reset_access;
    set_csr(32'h55);
    issue(2'b01, 1'b0, 5'd0, 32'h99, 1'b0, 1'b0, MSCRATCH, 44'h14, 2'd0);
    reset = 1'b1;
    #1;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rsta_write_en got %b exp 0", write_enable); end
    @(negedge clk);
    reset = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsta_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rsta_req_ready got %b exp 1", req_ready); end
    checks++; if (mscratch !== 32'h55) begin errors++; $display("FAIL rsta_csr got %h exp 55", mscratch); end
    issue(2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, MSCRATCH, 44'h15, 2'd0);
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rsta_rd_we got %b exp 0", write_enable); end
    @(negedge clk);
    checks++; if (rsp_data !== 32'h55) begin errors++; $display("FAIL rsta_reread got %h exp 55", rsp_data); end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_uuid = '0;
    req_wid = '0;
    req_addr = '0;
    req_op = '0;
    req_use_imm = 1'b0;
    req_imm = '0;
    req_rs1_data = '0;
    req_rd_zero = 1'b0;
    req_src_zero = 1'b0;
    rsp_ready = 1'b1;
    test_reset();
    test_rw();
    test_set_clear();
    test_ro_imm();
    test_rd_zero();
    test_back_to_back();
    test_reset_access();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
# csr_access_ctrl

Initiator side of the core's CSR register-file port: accepts decoded CSR instructions (CSRRW/CSRRS/CSRRC and immediate forms) from the SFU issue path. Sequences the read, read-modify-write and write accesses into the CSR data block over its read/write port. Returns the old CSR value to writeback through a valid/ready response. One instruction is in flight at a time; the block sits between the SFU dispatch and the CSR data block inside each core.

## Interface
- XLEN, 32, data width of CSR values
- NW_WIDTH, 2, warp-id width
- UUID_WIDTH, 44, instruction uuid width
- CSR_ADDR_BITS, 12, CSR address width

Clocking: reset reset, synchronous, active-high; clock clk.

- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  instruction request valid
- req_ready  out  1  block can accept a request
- req_uuid  in  UUID_WIDTH  instruction uuid
- req_wid  in  NW_WIDTH  issuing warp
- req_addr  in  CSR_ADDR_BITS  CSR address
- req_op  in  2  01=RW, 10=RS, 11=RC, 00=read-only
- req_use_imm  in  1  source is zero-extended req_imm instead of req_rs1_data
- req_imm  in  5  immediate source
- req_rs1_data  in  XLEN  register source
- req_rd_zero  in  1  rd==x0
- req_src_zero  in  1  rs1==x0 / imm==0
- read_enable  out  1  CSR read strobe
- read_uuid, read_wid, read_addr  out  UUID_WIDTH/NW_WIDTH/CSR_ADDR_BITS  read qualifiers
- read_data_ro, read_data_rw  in  XLEN each  combinational read data, same cycle
- write_enable  out  1  CSR write strobe
- write_uuid, write_wid, write_addr  out  UUID_WIDTH/NW_WIDTH/CSR_ADDR_BITS  write qualifiers
- write_data  out  XLEN  value to write
- rsp_valid  out  1  response valid
- rsp_ready  in  1  writeback accepts response
- rsp_uuid, rsp_wid  out  UUID_WIDTH/NW_WIDTH  response tags
- rsp_data  out  XLEN  old CSR value; 0 if read suppressed

## Operation
- FSM states: IDLE, ACCESS, RSP.
- IDLE: req_ready=1. On req_valid, latch uuid/wid/addr/op/rd_zero/src_zero and src = use_imm ? XLEN'(imm) : rs1_data. Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - read_enable = ~(op==RW & rd_zero).
  - old = read_data_ro | read_data_rw when reading, else 0.
  - write_enable = (op==RW) | ((op==RS|op==RC) & ~src_zero). op 00 never writes.
  - write_data: RW→src; RS→old|src; RC→old&~src.
  - Register old into rsp_data. Go to RSP.
- RSP: rsp_valid=1 with latched tags/data until rsp_ready; then go to IDLE.
- read_* and write_* qualifiers are driven from latched registers. Strobes are asserted only in ACCESS.
- req_ready is 0 in ACCESS and RSP; upstream holds the request.

## Timing
- Reset: state=IDLE; rsp_valid=0, read_enable=0, write_enable=0, rsp_data=0, req_ready=1 from the first cycle after reset deasserts.
- Request accepted at edge T; ACCESS at cycle T+1 (strobes high); rsp_valid at T+2.
- Minimum 3 cycles per instruction with rsp_ready tied high.
- Backpressure: in RSP, rsp_* are stable while rsp_ready=0. The next request is accepted only after returning to IDLE.
- Reset in ACCESS or RSP: the instruction is dropped. No strobe is asserted after the reset edge. rsp_valid=0 next cycle.
- Simultaneous req_valid and reset: the request is ignored.
- Write and read of the same CSR in ACCESS: write_data uses pre-write data, since the CSR data block updates at the clock edge.

## Test plan
- CSRRW mscratch (0x340), rs1=0xDEADBEEF, rd≠x0, mscratch=0x11 → ACCESS: read_enable=1, write_enable=1, write_data=0xDEADBEEF; rsp_data=0x11 at T+2.
- CSRRS mscratch, rs1=0x0F0, old=0x00F → write_data=0x0FF. CSRRC same rs1, old=0x0FF → write_data=0x00F. rsp_data=old in both cases.
- CSRRSI with imm=0 (src_zero) on read-only CSR 0xF11 → write_enable=0 throughout; rsp_data=VENDOR_ID.
- CSRRW with rd=x0 → read_enable=0, write_enable=1, rsp_data=0.
- rsp_ready low for 5 cycles → rsp_valid and rsp_data stable; req_ready=0; a second request is accepted exactly 1 cycle after the handshake.
- Reset asserted in ACCESS → no write to mscratch (value unchanged on re-read); rsp_valid=0; req_ready=1 after reset.
